// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
// The fetch stage is the master: it drives the request and address, memory answers with
// an acknowledge and the fetched word in the same cycle.
interface fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_data_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a req/ack handshake and
// writes the IF/ID pipeline register under control of the hazard unit and branch redirect.
// Request and address are functions of registered state only, so the hazard/branch controls
// never reach the memory bus combinationally.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pc_select_i,
    input  logic [31:0]         branch_target_i,
    input  logic                pc_write_i,
    input  logic                if_write_i,
    input  logic                if_flush_i,
    fetch_unit_if.master        imem,
    output logic [31:0]         pc_o,
    output logic [31:0]         if_id_instr_o,
    output logic [31:0]         if_id_pc_plus4_o,
    output logic                if_id_valid_o
);

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StWait,
        StDiscard
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic        in_fetch;
    logic        avail;
    logic        advance;
    logic        flush;
    logic [31:0] instr_src;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;

    // Decode the current-cycle fetch conditions shared by the PC, FSM and IF/ID logic.
    always_comb begin
        in_fetch       = (state_q == StFetch);
        // An instruction is available either straight off the bus or from the park buffer.
        avail          = (in_fetch && imem.imem_ack_i) || (state_q == StWait);
        advance        = avail && pc_write_i && if_write_i && !pc_select_i;
        flush          = pc_select_i || if_flush_i;
        instr_src      = (state_q == StWait) ? buf_q : imem.imem_data_i;
        pc_plus4       = pc_q + 32'd4;
        // Low address bits of the target are meaningless for word fetch; drop them.
        target_aligned = branch_target_i & ~32'd3;
    end

    // Next-state logic for the fetch FSM, the park buffer and the drained address.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        drop_addr_d = drop_addr_q;
        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (pc_select_i && !imem.imem_ack_i) begin
                    // Request still outstanding: keep its address on the bus until it drains.
                    state_d     = StDiscard;
                    drop_addr_d = pc_q;
                end else if (pc_select_i) begin
                    state_d = StFetch;
                end else if (imem.imem_ack_i && advance) begin
                    state_d = StFetch;
                end else if (imem.imem_ack_i) begin
                    // Pipeline stalled: park the word so it is not fetched twice.
                    state_d = StWait;
                    buf_d   = imem.imem_data_i;
                end else begin
                    state_d = StFetch;
                end
            end
            StWait: begin
                if (advance || pc_select_i) begin
                    state_d = StFetch;
                end
            end
            StDiscard: begin
                if (imem.imem_ack_i) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // PC update: redirect wins over sequential advance, otherwise hold.
    always_comb begin
        pc_d = pc_q;
        if (pc_select_i) begin
            pc_d = target_aligned;
        end else if (advance) begin
            pc_d = pc_plus4;
        end
    end

    // IF/ID update: flush, load, memory-stall bubble, or hold.
    always_comb begin
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;
        if (flush) begin
            if_id_instr_d    = 32'd0;
            if_id_pc_plus4_d = 32'd0;
            if_id_valid_d    = 1'b0;
        end else if (if_write_i && avail) begin
            if_id_instr_d    = instr_src;
            if_id_pc_plus4_d = pc_plus4;
            if_id_valid_d    = 1'b1;
        end else if (if_write_i) begin
            if_id_instr_d    = 32'd0;
            if_id_pc_plus4_d = 32'd0;
            if_id_valid_d    = 1'b0;
        end
    end

    // State registers; reset abandons any in-flight request immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q          <= StBoot;
            pc_q             <= RESET_PC;
            buf_q            <= 32'd0;
            drop_addr_q      <= 32'd0;
            if_id_instr_q    <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
            if_id_valid_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            buf_q            <= buf_d;
            drop_addr_q      <= drop_addr_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
        end
    end

    // Bus and debug outputs, driven from registered state only.
    always_comb begin
        imem.imem_req_o  = (state_q == StFetch) || (state_q == StDiscard);
        imem.imem_addr_o = (state_q == StDiscard) ? drop_addr_q : pc_q;
        pc_o             = pc_q;
        if_id_instr_o    = if_id_instr_q;
        if_id_pc_plus4_o = if_id_pc_plus4_q;
        if_id_valid_o    = if_id_valid_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction-memory model with programmable ack
// latency answers every request; each task drives one scenario and checks outputs #1 after
// the rising edge.
module tb_fetch_unit;

    logic        clk_i;
    logic        rst_i;
    logic        pc_select_i;
    logic [31:0] branch_target_i;
    logic        pc_write_i;
    logic        if_write_i;
    logic        if_flush_i;
    logic [31:0] pc_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc_plus4_o;
    logic        if_id_valid_o;

    int n_tests;
    int n_fail;
    int lat;
    int wait_cnt;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pc_select_i     (pc_select_i),
        .branch_target_i (branch_target_i),
        .pc_write_i      (pc_write_i),
        .if_write_i      (if_write_i),
        .if_flush_i      (if_flush_i),
        .imem            (bus),
        .pc_o            (pc_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_pc_plus4_o(if_id_pc_plus4_o),
        .if_id_valid_o   (if_id_valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory content: low bits set so a real instruction never looks like a zero bubble.
    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr | 32'h0000_0013;
    endfunction

    // Ack once the request has waited `lat` cycles (lat=0 acks in the request cycle).
    assign bus.imem_ack_i  = bus.imem_req_o && (wait_cnt >= lat);
    assign bus.imem_data_i = instr_of(bus.imem_addr_o);

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= 0;
        end else if (bus.imem_req_o && !bus.imem_ack_i) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_defaults;
        pc_select_i     = 1'b0;
        branch_target_i = 32'd0;
        pc_write_i      = 1'b1;
        if_write_i      = 1'b1;
        if_flush_i      = 1'b0;
        lat             = 0;
    endtask

    // Leaves reset released #1 after an edge; the next edge is the first after release.
    task automatic do_reset;
        set_defaults();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic test_reset;
        set_defaults();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_tests++;
        if (bus.imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b expected 0", bus.imem_req_o);
        end
        n_tests++;
        if (bus.imem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 00000000", bus.imem_addr_o);
        end
        n_tests++;
        if (pc_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h expected 00000000", pc_o);
        end
        n_tests++;
        if (if_id_instr_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_instr: got %h expected 00000000", if_id_instr_o);
        end
        n_tests++;
        if (if_id_pc_plus4_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc4: got %h expected 00000000", if_id_pc_plus4_o);
        end
        n_tests++;
        if (if_id_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", if_id_valid_o);
        end
    endtask

    task automatic test_zero_wait;
        logic [31:0] exp_a;
        do_reset();
        n_tests++;
        if (bus.imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL zw_boot_req: got %b expected 0", bus.imem_req_o);
        end
        tick();
        n_tests++;
        if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0 || if_id_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_first_req: got req=%b addr=%h valid=%b expected 1 00000000 0",
                     bus.imem_req_o, bus.imem_addr_o, if_id_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_a = 32'(4 * (i + 1));
            n_tests++;
            if (bus.imem_addr_o !== exp_a || if_id_valid_o !== 1'b1 ||
                if_id_pc_plus4_o !== exp_a || if_id_instr_o !== instr_of(exp_a - 32'd4)) begin
                n_fail++;
                $display("FAIL zw_seq[%0d]: got addr=%h v=%b pc4=%h ins=%h expected %h 1 %h %h",
                         i, bus.imem_addr_o, if_id_valid_o, if_id_pc_plus4_o, if_id_instr_o,
                         exp_a, exp_a, instr_of(exp_a - 32'd4));
            end
        end
        // Flush alone bubbles IF/ID while the PC keeps advancing.
        if_flush_i = 1'b1;
        tick();
        if_flush_i = 1'b0;
        n_tests++;
        if (if_id_valid_o !== 1'b0 || bus.imem_addr_o !== 32'h10) begin
            n_fail++;
            $display("FAIL zw_flush: got valid=%b addr=%h expected 0 00000010",
                     if_id_valid_o, bus.imem_addr_o);
        end
        tick();
        n_tests++;
        if (if_id_instr_o !== instr_of(32'h10) || if_id_pc_plus4_o !== 32'h14) begin
            n_fail++;
            $display("FAIL zw_after_flush: got ins=%h pc4=%h expected %h 00000014",
                     if_id_instr_o, if_id_pc_plus4_o, instr_of(32'h10));
        end
    endtask

    task automatic test_mem_latency;
        do_reset();
        lat = 3;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (if_id_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
                n_fail++;
                $display("FAIL lat_bubble[%0d]: got valid=%b req=%b addr=%h expected 0 1 00000000",
                         i, if_id_valid_o, bus.imem_req_o, bus.imem_addr_o);
            end
        end
        tick();
        n_tests++;
        if (if_id_valid_o !== 1'b1 || if_id_instr_o !== instr_of(32'h0) ||
            if_id_pc_plus4_o !== 32'h4) begin
            n_fail++;
            $display("FAIL lat_load: got valid=%b ins=%h pc4=%h expected 1 %h 00000004",
                     if_id_valid_o, if_id_instr_o, if_id_pc_plus4_o, instr_of(32'h0));
        end
    endtask

    task automatic test_stall;
        do_reset();
        tick();
        tick();
        pc_write_i = 1'b0;
        if_write_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (bus.imem_req_o !== 1'b0 || if_id_valid_o !== 1'b1 ||
                if_id_instr_o !== instr_of(32'h0) || pc_o !== 32'h4) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got req=%b valid=%b ins=%h pc=%h expected 0 1 %h 00000004",
                         i, bus.imem_req_o, if_id_valid_o, if_id_instr_o, pc_o, instr_of(32'h0));
            end
        end
        pc_write_i = 1'b1;
        if_write_i = 1'b1;
        tick();
        n_tests++;
        if (if_id_valid_o !== 1'b1 || if_id_instr_o !== instr_of(32'h4) ||
            if_id_pc_plus4_o !== 32'h8 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b ins=%h pc4=%h req=%b addr=%h expected 1 %h 00000008 1 00000008",
                     if_id_valid_o, if_id_instr_o, if_id_pc_plus4_o, bus.imem_req_o,
                     bus.imem_addr_o, instr_of(32'h4));
        end
    endtask

    // Runs to the point where the fetch of 0x8 is on the bus and will wait 3 cycles.
    task automatic prime_unacked_fetch;
        do_reset();
        tick();
        tick();
        tick();
        lat = 3;
    endtask

    task automatic test_redirect;
        prime_unacked_fetch();
        pc_select_i     = 1'b1;
        branch_target_i = 32'h40;
        tick();
        pc_select_i = 1'b0;
        n_tests++;
        if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8 || if_id_valid_o !== 1'b0 ||
            pc_o !== 32'h40) begin
            n_fail++;
            $display("FAIL redir_enter: got req=%b addr=%h valid=%b pc=%h expected 1 00000008 0 00000040",
                     bus.imem_req_o, bus.imem_addr_o, if_id_valid_o, pc_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (bus.imem_addr_o !== 32'h8 || if_id_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL redir_drain[%0d]: got addr=%h valid=%b expected 00000008 0",
                         i, bus.imem_addr_o, if_id_valid_o);
            end
        end
        tick();
        n_tests++;
        if (bus.imem_addr_o !== 32'h40 || bus.imem_req_o !== 1'b1 || if_id_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_target: got addr=%h req=%b valid=%b expected 00000040 1 0",
                     bus.imem_addr_o, bus.imem_req_o, if_id_valid_o);
        end
        lat = 0;
        tick();
        n_tests++;
        if (if_id_instr_o !== instr_of(32'h40) || if_id_pc_plus4_o !== 32'h44 ||
            if_id_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_load: got ins=%h pc4=%h valid=%b expected %h 00000044 1",
                     if_id_instr_o, if_id_pc_plus4_o, if_id_valid_o, instr_of(32'h40));
        end
    endtask

    task automatic test_double_redirect;
        prime_unacked_fetch();
        pc_select_i     = 1'b1;
        branch_target_i = 32'h40;
        tick();
        branch_target_i = 32'h80;
        tick();
        pc_select_i = 1'b0;
        n_tests++;
        if (bus.imem_addr_o !== 32'h8 || pc_o !== 32'h80) begin
            n_fail++;
            $display("FAIL dredir_hold: got addr=%h pc=%h expected 00000008 00000080",
                     bus.imem_addr_o, pc_o);
        end
        tick();
        tick();
        n_tests++;
        if (bus.imem_addr_o !== 32'h80 || bus.imem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL dredir_target: got addr=%h req=%b expected 00000080 1",
                     bus.imem_addr_o, bus.imem_req_o);
        end
        lat = 0;
        tick();
        n_tests++;
        if (if_id_instr_o !== instr_of(32'h80) || if_id_pc_plus4_o !== 32'h84) begin
            n_fail++;
            $display("FAIL dredir_load: got ins=%h pc4=%h expected %h 00000084",
                     if_id_instr_o, if_id_pc_plus4_o, instr_of(32'h80));
        end
    endtask

    task automatic test_wrap;
        do_reset();
        tick();
        pc_select_i     = 1'b1;
        branch_target_i = 32'hFFFF_FFFF;
        tick();
        pc_select_i = 1'b0;
        n_tests++;
        if (bus.imem_addr_o !== 32'hFFFF_FFFC || if_id_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_target: got addr=%h valid=%b expected fffffffc 0",
                     bus.imem_addr_o, if_id_valid_o);
        end
        tick();
        n_tests++;
        if (bus.imem_addr_o !== 32'h0 || if_id_pc_plus4_o !== 32'h0 || if_id_valid_o !== 1'b1 ||
            if_id_instr_o !== instr_of(32'hFFFF_FFFC)) begin
            n_fail++;
            $display("FAIL wrap_next: got addr=%h pc4=%h valid=%b ins=%h expected 00000000 00000000 1 %h",
                     bus.imem_addr_o, if_id_pc_plus4_o, if_id_valid_o, if_id_instr_o,
                     instr_of(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        tick();
        tick();
        pc_write_i = 1'b0;
        if_write_i = 1'b0;
        tick();
        n_tests++;
        if (bus.imem_req_o !== 1'b0 || if_id_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_wait: got req=%b valid=%b expected 0 1",
                     bus.imem_req_o, if_id_valid_o);
        end
        #3;
        rst_i = 1'b0;
        #1;
        n_tests++;
        if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h0 || pc_o !== 32'h0 ||
            if_id_instr_o !== 32'h0 || if_id_pc_plus4_o !== 32'h0 || if_id_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_clear: got req=%b addr=%h pc=%h ins=%h pc4=%h valid=%b expected all 0",
                     bus.imem_req_o, bus.imem_addr_o, pc_o, if_id_instr_o, if_id_pc_plus4_o,
                     if_id_valid_o);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_zero_wait();
        test_mem_latency();
        test_stall();
        test_redirect();
        test_double_redirect();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the hazard detection unit and the ID stage. It owns the PC register and issues requests to instruction memory over a req/ack handshake that may take one or more cycles. It writes the IF/ID pipeline register that the ID stage and hazard detection unit consume. It obeys the hazard unit's PC_Write / IF_Write / IF_Flush controls and the branch redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk_i  in  1  pipeline clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- pc_select_i  in  1  branch taken; redirect fetch to branch_target_i.
- branch_target_i  in  32  redirect address.
- pc_write_i  in  1  hazard unit PC_Write; 0 holds the PC.
- if_write_i  in  1  hazard unit IF_Write; 0 holds IF/ID.
- if_flush_i  in  1  hazard unit IF_Flush; loads a bubble into IF/ID.
- imem_req_o  out  1  request valid.
- imem_addr_o  out  32  request address, word aligned.
- imem_ack_i  in  1  request complete; imem_data_i is valid this cycle. May be asserted in the same cycle as the request.
- imem_data_i  in  32  fetched instruction.
- pc_o  out  32  current PC, for debug.
- if_id_instr_o  out  32  IF/ID instruction.
- if_id_pc_plus4_o  out  32  IF/ID address of the instruction + 4.
- if_id_valid_o  out  1  IF/ID holds a real instruction; 0 means bubble.

## Operation
- States:
  - BOOT: req=0.
  - FETCH: req=1, addr=pc_q.
  - WAIT: req=0; the fetched instruction is held in buf_q.
  - DISCARD: req=1, addr=drop_addr_q; the returning data is dropped.
- avail: (FETCH & imem_ack_i) | WAIT. The instruction source is imem_data_i in FETCH and buf_q in WAIT.
- advance: avail & pc_write_i & if_write_i & !pc_select_i.
- flush: pc_select_i | if_flush_i.
- IF/ID update, in priority order:
  - flush → instr=0, valid=0, pc_plus4=0.
  - else if_write_i & avail → load instr, pc_q+4, valid=1.
  - else if_write_i & !avail → bubble (memory stall).
  - else hold.
- PC update, in priority order:
  - pc_select_i → branch_target_i.
  - else advance → pc_q+4.
  - else hold.
- PC arithmetic is modulo 2^32, so 32'hFFFF_FFFC+4 = 0. Bits [1:0] of branch_target_i are ignored and forced to 0.
- Transitions:
  - BOOT → FETCH unconditionally. A redirect in BOOT still loads the PC.
  - FETCH, redirect & !ack → DISCARD; drop_addr_q ← pc_q.
  - FETCH, redirect & ack → FETCH, at the new PC.
  - FETCH, ack & advance → FETCH. The next request starts the following cycle at pc_q+4.
  - FETCH, ack & !advance & !redirect → WAIT; buf_q ← imem_data_i.
  - FETCH, !ack & !redirect → FETCH, with the address held stable.
  - WAIT, advance or redirect → FETCH.
  - WAIT, otherwise → stay in WAIT.
  - DISCARD, ack → FETCH, at pc_q (the latest target).
  - DISCARD, !ack → stay in DISCARD. A further redirect only updates pc_q.
- Handshake rule: while req=1 and ack=0, the address must not change. A redirect never abandons an outstanding request; DISCARD exists to drain it.
- Reset mid-request drops the request unconditionally. Memory must tolerate an abandoned request after reset.

## Timing
- Reset values:
  - pc_q=RESET_PC, state=BOOT.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - if_id_instr_o=0, if_id_pc_plus4_o=0, if_id_valid_o=0.
  - buf_q=0, drop_addr_q=0.
- First request: first clock edge after rst_i deasserts (BOOT→FETCH). req is high in the following cycle.
- Zero-wait memory (ack in the request cycle): IF/ID loads on that same edge, giving 1 instruction per cycle.
- N-cycle memory: IF/ID receives N bubbles, then the instruction.
- Redirect: IF/ID holds a bubble in the cycle after pc_select_i. The target request issues in the next cycle if no request is outstanding; otherwise it issues in the cycle after the outstanding ack.
- Stall (pc_write_i=if_write_i=0): IF/ID and PC are held. A fetched instruction is parked in WAIT with no re-fetch.
- All outputs are registered or derived from state/pc_q only. There is no combinational path from the *_i controls to imem_req_o or imem_addr_o.

## Test plan
- Reset release with RESET_PC=0, ack tied 1, data = addr:
  - imem_addr_o sequences 0,4,8.
  - IF/ID valid from the 2nd edge after release, pc_plus4 = 4,8,12.
- Memory ack delayed 3 cycles → IF/ID shows 3 bubbles, then instr at addr 0 with valid=1. Address is held at 0 throughout.
- Ack arrives while pc_write_i=if_write_i=0 for 2 cycles:
  - enters WAIT, req=0, IF/ID holds.
  - on release the buffered instr loads with no new request for the same address.
  - next request is pc+4.
- pc_select_i=1, target 0x40, while the request for 0x8 is unacked:
  - goes to DISCARD, addr stays 0x8 until ack, data dropped.
  - next request is 0x40.
  - IF/ID valid=0 throughout.
- Second redirect to 0x80 during DISCARD → the request after drain is 0x80, not 0x40.
- PC wrap, branch to 0xFFFF_FFFC, ack 1:
  - next address is 0x0.
  - if_id_pc_plus4_o = 0x0 for the instruction at 0xFFFF_FFFC.
- Bonus: rst_i asserted mid-WAIT → all outputs return to reset values immediately, asynchronously.
